// File: rtl/point_mul_dna.sv
`default_nettype none
// ============================================================================
// Module   : point_mul_dna (with point_mul_dna_pkg, ec_slope_core,
//            point_double, point_add)
// Brief    : MSB-first double-and-add scalar multiplier k*P on
//            y^2 = x^3 + A*x over GF(CURVE_P), affine coordinates.
// Revision : 1.0 - initial release
// ============================================================================

package point_mul_dna_pkg;
    localparam int P_WIDTH = 8;
    localparam logic [P_WIDTH-1:0] CURVE_P = P_WIDTH'(211);
    localparam logic [P_WIDTH-1:0] CURVE_A = P_WIDTH'(1);

    typedef struct packed {
        logic [P_WIDTH-1:0] x;
        logic [P_WIDTH-1:0] y;
    } curve_point_t;

    function automatic logic [P_WIDTH-1:0] f_mul(input logic [P_WIDTH-1:0] a,
                                                 input logic [P_WIDTH-1:0] b);
        logic [2*P_WIDTH-1:0] w_prod;
        logic [2*P_WIDTH-1:0] w_rem;
        w_prod = {{P_WIDTH{1'b0}}, a} * {{P_WIDTH{1'b0}}, b};
        w_rem  = w_prod % {{P_WIDTH{1'b0}}, CURVE_P};
        return w_rem[P_WIDTH-1:0];
    endfunction

    function automatic logic [P_WIDTH-1:0] f_add(input logic [P_WIDTH-1:0] a,
                                                 input logic [P_WIDTH-1:0] b);
        logic [P_WIDTH:0] w_s;
        w_s = {1'b0, a} + {1'b0, b};
        if (w_s >= {1'b0, CURVE_P})
            w_s = w_s - {1'b0, CURVE_P};
        return w_s[P_WIDTH-1:0];
    endfunction

    function automatic logic [P_WIDTH-1:0] f_sub(input logic [P_WIDTH-1:0] a,
                                                 input logic [P_WIDTH-1:0] b);
        if (a >= b)
            return a - b;
        else
            return a + (CURVE_P - b);
    endfunction
endpackage

// Shared slope engine: lambda = num/den via Fermat inversion, then the
// affine result x3 = l^2 - x1 - x2, y3 = l*(x1 - x3) - y1.
module ec_slope_core
    import point_mul_dna_pkg::*;
(
    input  logic               clk,
    input  logic               Reset,
    input  logic [P_WIDTH-1:0] i_num,
    input  logic [P_WIDTH-1:0] i_den,
    input  logic [P_WIDTH-1:0] i_x1,
    input  logic [P_WIDTH-1:0] i_y1,
    input  logic [P_WIDTH-1:0] i_x2,
    output curve_point_t       R,
    output logic               Done
);
    localparam logic [P_WIDTH-1:0] c_INV_EXP = CURVE_P - P_WIDTH'(2);
    localparam int c_BW = $clog2(P_WIDTH);

    typedef enum logic [2:0] {S_EXP, S_LAM, S_X3, S_Y3, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_BW-1:0]    r_bit;
    logic [P_WIDTH-1:0] r_num, r_den, r_x1, r_y1, r_x2;
    logic [P_WIDTH-1:0] r_acc, r_lam, r_x3;
    curve_point_t       r_res;
    logic               r_done;
    logic [P_WIDTH-1:0] w_sq;

    assign w_sq = f_mul(r_acc, r_acc);
    assign R    = r_res;
    assign Done = r_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_EXP:   if (r_bit == '0) w_next = S_LAM;
            S_LAM:   w_next = S_X3;
            S_X3:    w_next = S_Y3;
            S_Y3:    w_next = S_DONE;
            default: w_next = S_DONE;
        endcase
    end

    // Reset doubles as the launch strobe: operands are captured here.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_EXP;
            r_bit   <= c_BW'(P_WIDTH - 1);
            r_acc   <= P_WIDTH'(1);
            r_num   <= i_num;
            r_den   <= i_den;
            r_x1    <= i_x1;
            r_y1    <= i_y1;
            r_x2    <= i_x2;
            r_lam   <= '0;
            r_x3    <= '0;
            r_res   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_EXP: begin
                    r_acc <= c_INV_EXP[r_bit] ? f_mul(w_sq, r_den) : w_sq;
                    r_bit <= r_bit - c_BW'(1);
                end
                S_LAM: r_lam <= f_mul(r_num, r_acc);
                S_X3:  r_x3  <= f_sub(f_sub(f_mul(r_lam, r_lam), r_x1), r_x2);
                S_Y3: begin
                    r_res.x <= r_x3;
                    r_res.y <= f_sub(f_mul(r_lam, f_sub(r_x1, r_x3)), r_y1);
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

module point_double
    import point_mul_dna_pkg::*;
(
    input  logic         clk,
    input  logic         Reset,
    input  curve_point_t P,
    output curve_point_t R,
    output logic         Done
);
    logic [P_WIDTH-1:0] w_xx;
    logic [P_WIDTH-1:0] w_num;
    logic [P_WIDTH-1:0] w_den;

    assign w_xx  = f_mul(P.x, P.x);
    assign w_num = f_add(f_add(f_add(w_xx, w_xx), w_xx), CURVE_A);
    assign w_den = f_add(P.y, P.y);

    ec_slope_core u_core (
        .clk   (clk),
        .Reset (Reset),
        .i_num (w_num),
        .i_den (w_den),
        .i_x1  (P.x),
        .i_y1  (P.y),
        .i_x2  (P.x),
        .R     (R),
        .Done  (Done)
    );
endmodule

module point_add
    import point_mul_dna_pkg::*;
(
    input  logic         clk,
    input  logic         Reset,
    input  curve_point_t P,
    input  curve_point_t Q,
    output curve_point_t R,
    output logic         Done
);
    ec_slope_core u_core (
        .clk   (clk),
        .Reset (Reset),
        .i_num (f_sub(Q.y, P.y)),
        .i_den (f_sub(Q.x, P.x)),
        .i_x1  (P.x),
        .i_y1  (P.y),
        .i_x2  (Q.x),
        .R     (R),
        .Done  (Done)
    );
endmodule

module point_mul_dna
    import point_mul_dna_pkg::*;
#(
    parameter int K_WIDTH = P_WIDTH
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       start,
    input  curve_point_t               P,
    input  logic [K_WIDTH-1:0]         k,
    output logic                       busy,
    output logic                       done,
    output curve_point_t               R,
    output logic                       R_inf,
    output logic [$clog2(K_WIDTH):0]   dbl_count,
    output logic [$clog2(K_WIDTH):0]   add_count
);
    localparam int c_IW = $clog2(K_WIDTH);
    localparam int c_CW = $clog2(K_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE, SCAN, DBL_START, DBL_WAIT, ADD_START, ADD_WAIT, NEXT, FINISH
    } state_t;

    state_t            r_state;
    state_t            w_next;
    curve_point_t      r_p;
    logic [K_WIDTH-1:0] r_k;
    logic [c_IW-1:0]   r_i;
    curve_point_t      r_acc;
    logic              r_zero;
    curve_point_t      r_res;
    logic              r_rinf;
    logic              r_busy;
    logic              r_done;
    logic [c_CW-1:0]   r_dbl;
    logic [c_CW-1:0]   r_add;

    logic              w_dbl_rst;
    logic              w_add_rst;
    logic              w_dbl_done;
    logic              w_add_done;
    curve_point_t      w_dbl_r;
    curve_point_t      w_add_r;

    point_double u_dbl (
        .clk   (clk),
        .Reset (w_dbl_rst),
        .P     (r_acc),
        .R     (w_dbl_r),
        .Done  (w_dbl_done)
    );

    point_add u_add (
        .clk   (clk),
        .Reset (w_add_rst),
        .P     (r_acc),
        .Q     (r_p),
        .R     (w_add_r),
        .Done  (w_add_done)
    );

    always_comb begin
        w_next    = r_state;
        w_dbl_rst = Reset || (r_state == DBL_START);
        w_add_rst = Reset || (r_state == ADD_START);
        case (r_state)
            IDLE:      if (start) w_next = (k == '0) ? FINISH : SCAN;
            SCAN:      if (r_k[r_i]) w_next = NEXT;
            NEXT:      w_next = (r_i == '0) ? FINISH : DBL_START;
            DBL_START: w_next = DBL_WAIT;
            DBL_WAIT:  if (w_dbl_done) w_next = r_k[r_i] ? ADD_START : NEXT;
            ADD_START: w_next = ADD_WAIT;
            ADD_WAIT:  if (w_add_done) w_next = NEXT;
            FINISH:    w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_k     <= '0;
            r_i     <= '0;
            r_acc   <= '0;
            r_zero  <= 1'b0;
            r_res   <= '0;
            r_rinf  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbl   <= '0;
            r_add   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (start) begin
                    r_p    <= P;
                    r_k    <= k;
                    r_i    <= c_IW'(K_WIDTH - 1);
                    r_zero <= (k == '0);
                    r_busy <= 1'b1;
                    r_done <= 1'b0;
                    r_dbl  <= '0;
                    r_add  <= '0;
                end
                // Leading zeros are skipped; the first set bit seeds acc with P.
                SCAN: begin
                    if (r_k[r_i])
                        r_acc <= r_p;
                    else
                        r_i <= r_i - c_IW'(1);
                end
                NEXT: if (r_i != '0) r_i <= r_i - c_IW'(1);
                DBL_WAIT: if (w_dbl_done) begin
                    r_acc <= w_dbl_r;
                    r_dbl <= r_dbl + c_CW'(1);
                end
                ADD_WAIT: if (w_add_done) begin
                    r_acc <= w_add_r;
                    r_add <= r_add + c_CW'(1);
                end
                FINISH: begin
                    r_res  <= r_zero ? '0 : r_acc;
                    r_rinf <= r_zero;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign R         = r_res;
    assign R_inf     = r_rinf;
    assign dbl_count = r_dbl;
    assign add_count = r_add;
endmodule

`default_nettype wire
